fp_round: RTL

- Back-end rounding stage for the FP arithmetic units.
- Consumes the unrounded record (uround_res_t: u_result, rs, round_en, invalid, exp_cout) produced by fp_mul and sibling units.
- Applies the IEEE-754 rounding mode and produces the final encoded result plus fflags.
- Two-stage valid/ready pipeline placed between the FP datapath and the register-file writeback.

---
 rtl/fp_pkg.sv | 57 +++++
 rtl/fp_round_core.sv | 93 +++++++++
 rtl/fp_round.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared FP formats, rounding modes, flag layout and
// per-format special-value constants used by the rounding back end.
package fp_pkg;

  typedef enum logic [1:0] {
    FP16,
    FP32,
    FP64
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } roundmode_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  function automatic int fp_width(fp_format_e f);
    case (f)
      FP16:    return 16;
      FP64:    return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int exp_width(fp_format_e f);
    case (f)
      FP16:    return 5;
      FP64:    return 11;
      default: return 8;
    endcase
  endfunction

  // unsigned magnitude of infinity: exponent all ones, mantissa zero
  function automatic logic [63:0] inf_mag(fp_format_e f);
    int e;
    int m;
    e = exp_width(f);
    m = fp_width(f) - 1 - e;
    return ((64'd1 << e) - 64'd1) << m;
  endfunction

  // largest finite magnitude sits one ulp below infinity
  function automatic logic [63:0] max_finite_mag(fp_format_e f);
    return inf_mag(f) - 64'd1;
  endfunction

endpackage

// File: rtl/fp_round_core.sv
// fp_round_core: combinational increment decision and the
// apply/overflow/underflow result select for fp_round.
module fp_round_core
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  localparam int FP_WIDTH = fp_width(FP_FORMAT),
  localparam int EXP_WIDTH = exp_width(FP_FORMAT),
  localparam int MANT_WIDTH = FP_WIDTH - 1 - EXP_WIDTH
) (
  input  logic [2:0]          dec_mode,
  input  logic                dec_sign,
  input  logic                dec_lsb,
  input  logic [1:0]          dec_rs,
  output logic                dec_inc,
  input  logic [2:0]          app_mode,
  input  logic [FP_WIDTH-1:0] app_val,
  input  logic [1:0]          app_rs,
  input  logic                app_round_en,
  input  logic                app_invalid,
  input  logic [1:0]          app_exp_cout,
  input  logic                app_inc,
  output logic [FP_WIDTH-1:0] app_result,
  output fflags_t             app_flags
);

  localparam logic [FP_WIDTH-2:0] INF_MAG =
    (FP_WIDTH-1)'(inf_mag(FP_FORMAT));
  localparam logic [FP_WIDTH-2:0] MAX_MAG =
    (FP_WIDTH-1)'(max_finite_mag(FP_FORMAT));

  logic                  sign;
  logic [EXP_WIDTH-1:0]  exp_q;
  logic [EXP_WIDTH-1:0]  exp_n;
  logic [MANT_WIDTH-1:0] mant;
  logic [MANT_WIDTH-1:0] mant_n;
  logic                  carry;
  logic                  to_inf;

  // round-up decision; reserved modes fall back to RNE
  always_comb begin
    dec_inc = 1'b0;
    unique case (1'b1)
      dec_mode == RTZ: dec_inc = 1'b0;
      dec_mode == RDN: dec_inc = dec_sign & (|dec_rs);
      dec_mode == RUP: dec_inc = ~dec_sign & (|dec_rs);
      dec_mode == RMM: dec_inc = dec_rs[1];
      default:
        dec_inc = dec_rs[1] & (dec_rs[0] | dec_lsb);
    endcase
  end

  // split fields, add increment, pick INF vs MAX on overflow
  always_comb begin
    sign  = app_val[FP_WIDTH-1];
    exp_q = app_val[FP_WIDTH-2 -: EXP_WIDTH];
    mant  = app_val[MANT_WIDTH-1:0];
    {carry, mant_n} = {1'b0, mant}
                    + {{MANT_WIDTH{1'b0}}, app_inc};
    exp_n = exp_q + {{(EXP_WIDTH-1){1'b0}}, carry};
    to_inf = 1'b1;
    unique case (1'b1)
      app_mode == RTZ: to_inf = 1'b0;
      app_mode == RDN: to_inf = sign;
      app_mode == RUP: to_inf = ~sign;
      default:         to_inf = 1'b1;
    endcase
  end

  // exp_cout underflow wins, then exp_cout overflow, then exp checks
  always_comb begin
    app_result   = app_val;
    app_flags    = '0;
    app_flags.nv = app_invalid;
    if (app_round_en) begin
      if (app_exp_cout[1] ||
          (app_exp_cout == 2'b00 && exp_q == '0)) begin
        app_result   = {sign, {(FP_WIDTH-1){1'b0}}};
        app_flags.uf = 1'b1;
        app_flags.nx = 1'b1;
      end else if (app_exp_cout == 2'b01 ||
                   exp_q == '1 || exp_n == '1) begin
        app_result   = {sign, to_inf ? INF_MAG : MAX_MAG};
        app_flags.of = 1'b1;
        app_flags.nx = 1'b1;
      end else begin
        app_result   = {sign, exp_n, mant_n};
        app_flags.nx = |app_rs;
      end
    end
  end

endmodule

// File: rtl/fp_round.sv
// fp_round: two-stage valid/ready IEEE-754 rounding back end.
// FP_ROUND_FLAGS_STICKY_EN enables the accumulated fflags register.
module fp_round
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  localparam int FP_WIDTH = fp_width(FP_FORMAT),
  localparam int URND_WIDTH = FP_WIDTH + 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [URND_WIDTH-1:0] urnd_result_i,
  input  logic [2:0]            rnd_mode_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [FP_WIDTH-1:0]   result_o,
  output logic [4:0]            fflags_o,
  input  logic                  clr_flags_i,
  output logic [4:0]            fflags_acc_o
);

  typedef struct packed {
    logic [FP_WIDTH-1:0] u_result;
    logic [1:0]          rs;
    logic                round_en;
    logic                invalid;
    logic [1:0]          exp_cout;
  } uround_res_t;

  uround_res_t         urnd;
  uround_res_t         s1_rec;
  logic [2:0]          s1_mode;
  logic                s1_inc;
  logic                s1_valid;
  logic                s2_valid;
  logic [FP_WIDTH-1:0] s2_result;
  fflags_t             s2_flags;
  logic                adv;
  logic                in_inc;
  logic [FP_WIDTH-1:0] app_result;
  fflags_t             app_flags;

  assign urnd        = urnd_result_i;
  assign adv         = ~s2_valid | out_ready_i;
  assign in_ready_o  = adv;
  assign out_valid_o = s2_valid;
  assign result_o    = s2_result;
  assign fflags_o    = s2_flags;

  fp_round_core #(
    .FP_FORMAT (FP_FORMAT)
  ) u_core (
    .dec_mode     (rnd_mode_i),
    .dec_sign     (urnd.u_result[FP_WIDTH-1]),
    .dec_lsb      (urnd.u_result[0]),
    .dec_rs       (urnd.rs),
    .dec_inc      (in_inc),
    .app_mode     (s1_mode),
    .app_val      (s1_rec.u_result),
    .app_rs       (s1_rec.rs),
    .app_round_en (s1_rec.round_en),
    .app_invalid  (s1_rec.invalid),
    .app_exp_cout (s1_rec.exp_cout),
    .app_inc      (s1_inc),
    .app_result   (app_result),
    .app_flags    (app_flags)
  );

  // S1 payload: record, mode and precomputed increment
  always_ff @(posedge clk_i) begin
    if (adv && in_valid_i) begin
      s1_rec  <= urnd;
      s1_mode <= rnd_mode_i;
      s1_inc  <= in_inc;
    end
  end

  // valids and S2 output register shift together on adv
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid_i;
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= app_result;
        s2_flags  <= app_flags;
      end
    end
  end

`ifdef FP_ROUND_FLAGS_STICKY_EN
  logic       hs;
  logic [4:0] acc_q;

  assign hs           = s2_valid & out_ready_i;
  assign fflags_acc_o = acc_q;

  // sticky OR of delivered flags; clear keeps only new flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (clr_flags_i) begin
      acc_q <= hs ? s2_flags : 5'b0;
    end else if (hs) begin
      acc_q <= acc_q | s2_flags;
    end
  end
`else
  logic unused_clr;

  assign unused_clr   = clr_flags_i;
  assign fflags_acc_o = '0;
`endif

endmodule
